bit_serial_adder: RTL and testbench

- Sequential controller that adds two WIDTH-bit operands one bit per clock through a single one_bit_adder instance, holding the carry between cycles in a flip-flop.
- Upstream side: a valid/ready operand interface. Downstream side: a valid/ready result interface carrying sum, carry-out, signed overflow, and per-bit propagate/generate masks collected from the adder's tap outputs.
- Used as the area-minimal adder stage ahead of the result consumers.

---
 rtl/bit_serial_adder_pkg.sv | 11 +
 rtl/one_bit_adder.sv | 19 +
 rtl/bit_serial_adder.sv | 151 +++++++++++++++
 tb/tb_bit_serial_adder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and the
// minimum legal operand width.
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/one_bit_adder.sv
// Single-bit full adder that also exposes its internal propagate/generate taps.
module one_bit_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout,
    output logic AxorB_out,
    output logic AandB_out,
    output logic PandCin_out
);

    assign AxorB_out   = A ^ B;
    assign AandB_out   = A & B;
    assign PandCin_out = AxorB_out & Cin;
    assign Sum         = AxorB_out ^ Cin;
    assign Cout        = AandB_out | PandCin_out;

endmodule

// File: rtl/bit_serial_adder.sv
// Adds two WIDTH-bit operands LSB first, one bit per clock, through a single
// full adder; results leave on a valid/ready handshake.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic [WIDTH-1:0] P_mask,
    output logic [WIDTH-1:0] G_mask
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_CIN = CNT_W'(WIDTH - 2);

    generate
        if (WIDTH < MIN_WIDTH) begin : g_width_check
            $error("bit_serial_adder: WIDTH must be at least 2");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic             msb_cin_q, msb_cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic add_sum, add_cout, add_p, add_g;
    logic pandcin_unused;

    one_bit_adder u_adder (
        .A           (a_sh_q[0]),
        .B           (b_sh_q[0]),
        .Cin         (carry_q),
        .Sum         (add_sum),
        .Cout        (add_cout),
        .AxorB_out   (add_p),
        .AandB_out   (add_g),
        .PandCin_out (pandcin_unused)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        p_d       = p_q;
        g_d       = g_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    p_d     = '0;
                    g_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_d   = {add_sum, sum_q[WIDTH-1:1]};
                p_d     = {add_p, p_q[WIDTH-1:1]};
                g_d     = {add_g, g_q[WIDTH-1:1]};
                carry_d = add_cout;
                // Carry out of bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_MSB_CIN) begin
                    msb_cin_d = add_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    cout_d  = add_cout;
                    ovf_d   = msb_cin_q ^ add_cout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            p_q       <= '0;
            g_q       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            p_q       <= p_d;
            g_q       <= g_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign P_mask    = p_q;
    assign G_mask    = g_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8) against an integer
// arithmetic reference model.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic [W-1:0] P_mask;
    logic [W-1:0] G_mask;

    int total = 0;
    int bad = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .P_mask    (P_mask),
        .G_mask    (G_mask)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer sums.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic ov,
                                  output logic [W-1:0] p, output logic [W-1:0] g);
        int full;
        int ssum;
        full = int'(a) + int'(b) + int'(c);
        ssum = int'($signed(a)) + int'($signed(b)) + int'(c);
        s  = full[W-1:0];
        co = (full > 255);
        ov = (ssum > 127) || (ssum < -128);
        p  = a ^ b;
        g  = a & b;
    endfunction

    // Offers one operand set, waits for acceptance, then for out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat);
        @(negedge clk);
        A = a; B = b; Cin = c; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        total++;
        if (Sum !== 8'h00 || Cout !== 1'b0 || Ovf !== 1'b0 || P_mask !== 8'h00 || G_mask !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: Sum=%h Cout=%b Ovf=%b P=%h G=%h required all zero",
                     Sum, Cout, Ovf, P_mask, G_mask);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[10];
        logic [W-1:0] vb[10];
        logic         vc[10];
        logic [W-1:0] es, ep, eg;
        logic         eco, eov;
        int lat;
        va[0] = 8'h5A; vb[0] = 8'h33; vc[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0;
        va[2] = 8'h80; vb[2] = 8'h80; vc[2] = 1'b0;
        va[3] = 8'h00; vb[3] = 8'h00; vc[3] = 1'b1;
        va[4] = 8'h7F; vb[4] = 8'h00; vc[4] = 1'b1;
        va[5] = 8'hFF; vb[5] = 8'hFF; vc[5] = 1'b1;
        for (int i = 6; i < 10; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vc[i] = 1'($urandom);
        end
        for (int i = 0; i < 10; i++) begin
            model(va[i], vb[i], vc[i], es, eco, eov, ep, eg);
            run_op(va[i], vb[i], vc[i], lat);
            $display("vec %0d: %h+%h+%0d -> Sum=%h Cout=%b Ovf=%b P=%h G=%h lat=%0d",
                     i, va[i], vb[i], vc[i], Sum, Cout, Ovf, P_mask, G_mask, lat);
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d required 8", i, lat);
            end
            total++;
            if (Sum !== es || Cout !== eco || Ovf !== eov) begin
                bad++;
                $display("FAIL vec%0d_sum: Sum=%h Cout=%b Ovf=%b required %h %b %b",
                         i, Sum, Cout, Ovf, es, eco, eov);
            end
            total++;
            if (P_mask !== ep || G_mask !== eg) begin
                bad++;
                $display("FAIL vec%0d_masks: P=%h G=%h required %h %h", i, P_mask, G_mask, ep, eg);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] es, ep, eg, held;
        logic         eco, eov;
        int lat;
        int stable_err;
        run_op(8'h5A, 8'h33, 1'b0, lat);
        held = Sum;
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b1; in_valid = 1'b1;
        stable_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Sum !== held || Sum !== 8'h8D)
                stable_err++;
        end
        total++;
        if (stable_err != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable cycles required 0 (Sum=%h in_ready=%b out_valid=%b)",
                     stable_err, Sum, in_ready, out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: in_ready=%b required 0 after pending operands", in_ready);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        model(8'h12, 8'h34, 1'b1, es, eco, eov, ep, eg);
        total++;
        if (lat !== 8 || Sum !== es || Cout !== eco || Ovf !== eov) begin
            bad++;
            $display("FAIL bp_next: lat=%0d Sum=%h Cout=%b Ovf=%b required 8 %h %b %b",
                     lat, Sum, Cout, Ovf, es, eco, eov);
        end
        $display("backpressure: held=%h next Sum=%h lat=%0d", held, Sum, lat);
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        @(negedge clk);
        A = 8'hFF; B = 8'h00; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (Sum !== 8'h00 || P_mask !== 8'h00 || G_mask !== 8'h00 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            bad++;
            $display("FAIL midrst_zero: Sum=%h P=%h G=%h Cout=%b Ovf=%b required zeros",
                     Sum, P_mask, G_mask, Cout, Ovf);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_noval: out_valid seen %0d cycles required 0", seen);
        end
        run_op(8'h5A, 8'h33, 1'b0, lat);
        total++;
        if (lat !== 8 || Sum !== 8'h8D || Cout !== 1'b0 || Ovf !== 1'b1) begin
            bad++;
            $display("FAIL midrst_next: lat=%0d Sum=%h Cout=%b Ovf=%b required 8 8d 0 1",
                     lat, Sum, Cout, Ovf);
        end
        $display("reset mid-run: next Sum=%h lat=%0d", Sum, lat);
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic         qc[$];
        logic [W-1:0] es, ep, eg, ra, rb;
        logic         eco, eov, rc;
        int last_acc = -1;
        int n_acc = 0;
        int n_done = 0;
        out_ready = 1'b1;
        @(negedge clk);
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); in_valid = 1'b1;
        for (int t = 0; t < 20000 && n_done < 1000; t++) begin
            logic acc;
            logic ret;
            acc = in_valid && in_ready;
            ret = out_valid;
            if (acc) begin
                qa.push_back(A); qb.push_back(B); qc.push_back(Cin);
                n_acc++;
                if (last_acc >= 0) begin
                    total++;
                    if (t - last_acc != 10) begin
                        bad++;
                        $display("FAIL b2b_interval: got %0d required 10", t - last_acc);
                    end
                end
                last_acc = t;
            end
            if (ret) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious: out_valid with no operation pending");
                end else begin
                    ra = qa.pop_front(); rb = qb.pop_front(); rc = qc.pop_front();
                    model(ra, rb, rc, es, eco, eov, ep, eg);
                    $display("b2b %0d: %h+%h+%0d -> Sum=%h Cout=%b Ovf=%b", n_done, ra, rb, rc, Sum, Cout, Ovf);
                    if (Sum !== es || Cout !== eco || Ovf !== eov || P_mask !== ep || G_mask !== eg) begin
                        bad++;
                        $display("FAIL b2b_result: Sum=%h Cout=%b Ovf=%b P=%h G=%h required %h %b %b %h %h",
                                 Sum, Cout, Ovf, P_mask, G_mask, es, eco, eov, ep, eg);
                    end
                end
                n_done++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (n_acc < 1000) begin
                    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        total++;
        if (n_done != 1000) begin
            bad++;
            $display("FAIL b2b_count: completed %0d required 1000", n_done);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
